// File: rtl/font_rom_arbiter_if.sv
// Bus between the text-overlay clients, font_rom_arbiter and the shared font ROM.
// slave = arbiter side; master = clients plus ROM.
interface font_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      rom_en;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rd_valid, rd_data, rom_en, rom_addr
  );

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rd_valid, rd_data, rom_en, rom_addr
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM among NUM_REQ overlay clients, with tagged read returns.
// Define FONT_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (client 0 highest).
module font_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  font_rom_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic             found;
  logic [PTR_W-1:0] winner;

  logic [NUM_REQ-1:0] gnt_q;
  logic               rom_en_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [PTR_W-1:0]   issueId_q;
  logic [ROM_LAT-1:0] tagValid_q;
  logic [PTR_W-1:0]   tagId_q [ROM_LAT];
  logic [NUM_REQ-1:0] rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;

`ifdef FONT_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        found  = 1'b1;
        winner = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  int               sum;

  // Search starts at ptr and wraps modulo NUM_REQ; the winner's successor gets priority next.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    sum    = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      sum = int'(ptr_q) + o;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      issueId_q  <= '0;
      tagValid_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) tagId_q[i] <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      gnt_q     <= found ? (ONE_HOT0 << winner) : '0;
      rom_en_q  <= found;
      issueId_q <= winner;
      if (found) rom_addr_q <= bus.req_addr[winner*ADDR_W +: ADDR_W];

      // Tag stage ROM_LAT-1 lines up with the cycle rom_data is valid.
      tagValid_q[0] <= rom_en_q;
      tagId_q[0]    <= issueId_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagId_q[i]    <= tagId_q[i-1];
      end

      rd_valid_q <= tagValid_q[ROM_LAT-1] ? (ONE_HOT0 << tagId_q[ROM_LAT-1]) : '0;
      if (tagValid_q[ROM_LAT-1]) rd_data_q <= bus.rom_data;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter with a one-cycle synchronous ROM stub.
// ROM content is addr[7:0] ^ {addr[10:8], 5'h15}.
module tb_font_rom_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] gntTab  [3] = '{3'b001, 3'b010, 3'b100};
  logic [10:0] addrTab [3] = '{11'h010, 11'h020, 11'h030};
  logic [7:0] dataTab [3] = '{8'h05, 8'h35, 8'h25};
  logic [2:0] wrapTab [4] = '{3'b100, 3'b001, 3'b100, 3'b001};

  font_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  font_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romModel(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'h15};
  endfunction

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= romModel(bus.rom_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tickCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstV, input logic [2:0] reqV, input logic [32:0] addrV);
    rst          = rstV;
    bus.req      = reqV;
    bus.req_addr = addrV;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 3'b000, 33'h0);
    tickCycle();
    tickCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 3'b000, 33'h0);
    tickCycle();
    tickCycle();
    checkOutput("reset_gnt",      32'(bus.gnt),      32'h0);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    checkOutput("reset_rd_data",  32'(bus.rd_data),  32'h0);
    checkOutput("reset_rom_en",   32'(bus.rom_en),   32'h0);
    checkOutput("reset_rom_addr", 32'(bus.rom_addr), 32'h0);

`ifndef FONT_ARB_FIXED_PRIO_EN
    $display("[TB] single client");
    applyStimulus(1'b0, 3'b010, {11'h7FF, 11'h2A3, 11'h155});
    tickCycle();
    checkOutput("single_gnt",      32'(bus.gnt),      32'h2);
    checkOutput("single_rom_en",   32'(bus.rom_en),   32'h1);
    checkOutput("single_rom_addr", 32'(bus.rom_addr), 32'h2A3);
    checkOutput("single_rv_early", 32'(bus.rd_valid), 32'h0);
    applyStimulus(1'b0, 3'b000, {11'h7FF, 11'h2A3, 11'h155});
    tickCycle();
    checkOutput("single_idle_gnt",  32'(bus.gnt),      32'h0);
    checkOutput("single_idle_en",   32'(bus.rom_en),   32'h0);
    checkOutput("single_addr_hold", 32'(bus.rom_addr), 32'h2A3);
    checkOutput("single_rv_mid",    32'(bus.rd_valid), 32'h0);
    tickCycle();
    checkOutput("single_rd_valid", 32'(bus.rd_valid), 32'h2);
    checkOutput("single_rd_data",  32'(bus.rd_data),  32'hF6);
    tickCycle();
    checkOutput("single_rv_after", 32'(bus.rd_valid), 32'h0);
    checkOutput("single_data_hold", 32'(bus.rd_data), 32'hF6);

    $display("[TB] all clients, rotation");
    doReset();
    applyStimulus(1'b0, 3'b111, {11'h030, 11'h020, 11'h010});
    for (int i = 0; i < 11; i++) begin
      tickCycle();
      checkOutput($sformatf("rot_gnt_%0d", i), 32'(bus.gnt), (i < 9) ? 32'(gntTab[i % 3]) : 32'h0);
      if (i < 9) checkOutput($sformatf("rot_addr_%0d", i), 32'(bus.rom_addr), 32'(addrTab[i % 3]));
      if (i >= 2) begin
        checkOutput($sformatf("rot_rv_%0d", i), 32'(bus.rd_valid), 32'(gntTab[(i - 2) % 3]));
        checkOutput($sformatf("rot_data_%0d", i), 32'(bus.rd_data), 32'(dataTab[(i - 2) % 3]));
      end else begin
        checkOutput($sformatf("rot_rv_%0d", i), 32'(bus.rd_valid), 32'h0);
      end
      if (i == 8) applyStimulus(1'b0, 3'b000, {11'h030, 11'h020, 11'h010});
    end

    $display("[TB] pointer wrap");
    doReset();
    applyStimulus(1'b0, 3'b010, {11'h003, 11'h002, 11'h001});
    tickCycle();
    checkOutput("wrap_setup_gnt", 32'(bus.gnt), 32'h2);
    applyStimulus(1'b0, 3'b101, {11'h003, 11'h002, 11'h001});
    for (int k = 0; k < 4; k++) begin
      tickCycle();
      checkOutput($sformatf("wrap_gnt_%0d", k), 32'(bus.gnt), 32'(wrapTab[k]));
      if (k == 1) begin
        checkOutput("wrap_rv_1",   32'(bus.rd_valid), 32'h2);
        checkOutput("wrap_data_1", 32'(bus.rd_data),  32'h17);
      end
      if (k == 2) begin
        checkOutput("wrap_rv_2",   32'(bus.rd_valid), 32'h4);
        checkOutput("wrap_data_2", 32'(bus.rd_data),  32'h16);
      end
    end
    applyStimulus(1'b0, 3'b000, 33'h0);
    tickCycle();
    tickCycle();
    tickCycle();

    $display("[TB] reset mid-flight");
    doReset();
    applyStimulus(1'b0, 3'b111, {11'h030, 11'h020, 11'h010});
    tickCycle();
    checkOutput("mid_gnt0", 32'(bus.gnt), 32'h1);
    tickCycle();
    checkOutput("mid_gnt1", 32'(bus.gnt), 32'h2);
    applyStimulus(1'b1, 3'b000, 33'h0);
    tickCycle();
    checkOutput("mid_rst_gnt",  32'(bus.gnt),      32'h0);
    checkOutput("mid_rst_en",   32'(bus.rom_en),   32'h0);
    checkOutput("mid_rst_addr", 32'(bus.rom_addr), 32'h0);
    checkOutput("mid_rst_rv",   32'(bus.rd_valid), 32'h0);
    checkOutput("mid_rst_data", 32'(bus.rd_data),  32'h0);
    applyStimulus(1'b0, 3'b000, 33'h0);
    for (int i = 0; i < 5; i++) begin
      tickCycle();
      checkOutput($sformatf("mid_after_rv_%0d", i), 32'(bus.rd_valid), 32'h0);
      checkOutput($sformatf("mid_after_data_%0d", i), 32'(bus.rd_data), 32'h0);
    end

    $display("[TB] dropped request");
    doReset();
    applyStimulus(1'b0, 3'b101, {11'h044, 11'h000, 11'h011});
    tickCycle();
    checkOutput("drop_gnt_first", 32'(bus.gnt), 32'h1);
    applyStimulus(1'b0, 3'b001, {11'h044, 11'h000, 11'h011});
    for (int i = 0; i < 5; i++) begin
      tickCycle();
      checkOutput($sformatf("drop_gnt_%0d", i), 32'(bus.gnt), 32'h1);
      checkOutput($sformatf("drop_rv2_%0d", i), 32'(bus.rd_valid[2]), 32'h0);
    end
    checkOutput("drop_rv0", 32'(bus.rd_valid), 32'h1);
    applyStimulus(1'b0, 3'b000, 33'h0);
    tickCycle();
    tickCycle();
    tickCycle();
`else
    $display("[TB] fixed priority");
    doReset();
    applyStimulus(1'b0, 3'b111, {11'h030, 11'h020, 11'h010});
    for (int i = 0; i < 5; i++) begin
      tickCycle();
      checkOutput($sformatf("fix_gnt_%0d", i), 32'(bus.gnt), 32'h1);
      checkOutput($sformatf("fix_addr_%0d", i), 32'(bus.rom_addr), 32'h010);
      if (i >= 2) begin
        checkOutput($sformatf("fix_rv_%0d", i), 32'(bus.rd_valid), 32'h1);
        checkOutput($sformatf("fix_data_%0d", i), 32'(bus.rd_data), 32'h05);
      end
    end
    applyStimulus(1'b0, 3'b110, {11'h030, 11'h020, 11'h010});
    tickCycle();
    checkOutput("fix_gnt_c1",  32'(bus.gnt),      32'h2);
    checkOutput("fix_addr_c1", 32'(bus.rom_addr), 32'h020);
    applyStimulus(1'b0, 3'b100, {11'h030, 11'h020, 11'h010});
    tickCycle();
    checkOutput("fix_gnt_c2", 32'(bus.gnt), 32'h4);
    applyStimulus(1'b0, 3'b000, 33'h0);
    tickCycle();
    checkOutput("fix_rv_c1",   32'(bus.rd_valid), 32'h2);
    checkOutput("fix_data_c1", 32'(bus.rd_data),  32'h35);
    tickCycle();
    checkOutput("fix_rv_c2",   32'(bus.rd_valid), 32'h4);
    checkOutput("fix_data_c2", 32'(bus.rd_data),  32'h25);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
